// File: rtl/code_comb_seq_if.sv
// Result stream between the sweep controller and its consumer.
interface code_comb_seq_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [5:0] out_mm;
    logic       out_last;

    modport master (
        output out_valid,
        output out_result,
        output out_mm,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_result,
        input  out_mm,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/code_comb_seq.sv
// Sweep controller: walks index pairs {M,m} through an external comb datapath,
// registers each result, hands it out with valid/ready and keeps a running checksum.
module code_comb_seq #(
    parameter int unsigned CHK_W = 14
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [31:0]          data_in,
    input  logic [5:0]           mm_cfg,
    output logic [31:0]          comb_data,
    output logic [5:0]           mm_o,
    input  logic [7:0]           comb_result,
    code_comb_seq_if.master      out_if,
    output logic                 busy,
    output logic                 done,
    output logic [CHK_W-1:0]     checksum
);

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        comb_data_q, comb_data_d;
    logic [1:0]         mode_q, mode_d;
    logic [5:0]         pair_q, pair_d;
    logic               valid_q, valid_d;
    logic [7:0]         result_q, result_d;
    logic [5:0]         mm_q, mm_d;
    logic               last_q, last_d;
    logic [CHK_W-1:0]   checksum_q, checksum_d;

    logic [5:0]         first_pair;
    logic [5:0]         next_pair;
    logic               pair_final;

    // Pair sequencing: diagonal steps M and m together (+9), full counts 0..63.
    always_comb begin
        first_pair = (mode[1]) ? mm_cfg : 6'd0;
        next_pair  = (mode_q == 2'd0) ? pair_q + 6'd9 : pair_q + 6'd1;
        unique case (mode_q)
            2'd0:    pair_final = (pair_q == 6'o77);
            2'd1:    pair_final = (pair_q == 6'd63);
            default: pair_final = 1'b1;
        endcase
    end

    // Next-state logic; abort wins over a simultaneous handshake.
    always_comb begin
        state_d     = state_q;
        comb_data_d = comb_data_q;
        mode_d      = mode_q;
        pair_d      = pair_q;
        valid_d     = valid_q;
        result_d    = result_q;
        mm_d        = mm_q;
        last_d      = last_q;
        checksum_d  = checksum_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    comb_data_d = data_in;
                    mode_d      = mode;
                    pair_d      = first_pair;
                    checksum_d  = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    valid_d  = 1'b1;
                    result_d = comb_result;
                    mm_d     = pair_q;
                    last_d   = pair_final;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (out_if.out_ready) begin
                    checksum_d = checksum_q + {{(CHK_W - 8){1'b0}}, result_q};
                    valid_d    = 1'b0;
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        pair_d  = next_pair;
                        state_d = StRun;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            comb_data_q <= '0;
            mode_q      <= '0;
            pair_q      <= '0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            mm_q        <= '0;
            last_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            comb_data_q <= comb_data_d;
            mode_q      <= mode_d;
            pair_q      <= pair_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            mm_q        <= mm_d;
            last_q      <= last_d;
            checksum_q  <= checksum_d;
        end
    end

    // Outputs; mm_o is forced to 0 in IDLE so the datapath sees a quiet index.
    always_comb begin
        comb_data         = comb_data_q;
        mm_o              = (state_q == StIdle) ? 6'd0 : pair_q;
        busy              = (state_q != StIdle);
        done              = (state_q == StDone);
        checksum          = checksum_q;
        out_if.out_valid  = valid_q;
        out_if.out_result = result_q;
        out_if.out_mm     = mm_q;
        out_if.out_last   = last_q;
    end

endmodule

// File: doc/code_comb_seq.md
CODE_COMB_SEQ -- requirements
Module: code_comb_seq

Interface
REQ-001 SHALL have parameter CHK_W, default 14, checksum width in bits; it is at least 14.
REQ-002 SHALL have port sysclk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  in  1  single-cycle request to begin a sweep, accepted only in IDLE.
REQ-005 SHALL have port abort  in  1  synchronous cancel of the current sweep.
REQ-006 SHALL have port mode  in  2  sweep mode, where 0 = diagonal, 1 = full, 2 = single and 3 = single.
REQ-007 SHALL have port data_in  in  32  data word, eight 4-bit nibbles, where nibble k = data_in[4k+3:4k].
REQ-008 SHALL have port mm_cfg  in  6  pair for single mode, as {M2M1M0, m2m1m0}.
REQ-009 SHALL have port comb_data  out  32  latched data word driven to the comb datapath.
REQ-010 SHALL have port mm_o  out  6  index pair driven to the comb datapath.
REQ-011 SHALL have port comb_result  in  8  datapath output, contract {nibble[M], nibble[m]}, combinational from comb_data/mm_o within the same cycle.
REQ-012 SHALL have port out_valid  out  1  result available.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-014 SHALL have port out_result  out  8  registered comb_result.
REQ-015 SHALL have port out_mm  out  6  pair that produced out_result.
REQ-016 SHALL have port out_last  out  1  marks the final result of the sweep.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse at sweep completion.
REQ-019 SHALL have port checksum  out  CHK_W  running sum of accepted out_result values.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HOLD and DONE.
REQ-021 SHALL, in IDLE when start=1, latch data_in into comb_data, latch mode, load the first pair, clear checksum, and go to RUN.
REQ-022 SHALL set the first pair by mode: 0 gives {0,0}, 1 gives 6'd0, and 2/3 give mm_cfg.
REQ-023 SHALL, in RUN, drive mm_o with the current pair, register comb_result into out_result and mm_o into out_mm at the clock edge, set out_valid=1 and out_last = (pair is final), and go to HOLD.
REQ-024 SHALL, in HOLD, hold out_valid, out_result, out_mm, out_last, mm_o and comb_data stable while out_ready=0.
REQ-025 SHALL, on a HOLD handshake (out_valid and out_ready), add out_result (zero-extended) to checksum and clear out_valid; next state is DONE if out_last, else RUN with the pair advanced.
REQ-026 SHALL advance the pair in mode 0 as M=m=k, k = 0..7, with k=7 final.
REQ-027 SHALL advance the pair in mode 1 as {M,m} counting 0..63, with 63 final.
REQ-028 SHALL treat the single pair in modes 2/3 as final.
REQ-029 SHALL, in DONE, assert done=1 for exactly one cycle and go to IDLE; checksum holds until the next accepted start.
REQ-030 SHALL give throughput of one result per 2 cycles with out_ready held high.
REQ-031 SHALL give start-to-first-out_valid latency of 2 cycles, and last handshake to done of 1 cycle.
REQ-032 SHALL ignore start while busy=1.
REQ-033 SHALL, when abort=1 in RUN, HOLD or DONE, go to IDLE next cycle with out_valid=0 and done=0; checksum is kept.
REQ-034 SHALL give abort priority over a simultaneous handshake; the pending result is discarded and not summed.
REQ-035 SHALL ignore abort in IDLE, and a simultaneous start in IDLE is accepted.
REQ-036 SHALL keep mm_o at 0 in IDLE.
REQ-037 SHALL not update checksum on abort or in idle cycles.

Reset
REQ-038 SHALL, while rst_n=0, immediately force state to IDLE and all outputs to 0: comb_data, mm_o, out_valid, out_result, out_mm, out_last, busy, done and checksum.
REQ-039 SHALL, on reset mid-sweep, drop the sweep with no done pulse; operation resumes on the first start after rst_n rises.

Verification (data_in = 32'h76543210)
REQ-040 SHALL cover: mode 0, out_ready=1 -> 8 results 0x00,0x11,...,0x77 every 2 cycles, out_last on 0x77, checksum 0x1DC, done 1 cycle later.
REQ-041 SHALL cover: mode 2, mm_cfg=6'b111000 -> single out_result 0x70, out_mm 0x38, out_last=1; a second run with mm_cfg=6'b000111 -> 0x07.
REQ-042 SHALL cover: mode 1 with out_ready toggling randomly -> 64 results in {M,m} order, each equal to {M,m} as nibbles, checksum 0xEE0, exactly one done.
REQ-043 SHALL cover: out_ready low 5 cycles in HOLD (e.g. at pair 6'b101101, result 0x55) -> out_valid, out_result, out_mm and mm_o unchanged throughout.
REQ-044 SHALL cover: abort asserted in HOLD of mode 1 at pair 10 together with out_ready=1 -> IDLE next cycle, out_valid=0, checksum = sum of pairs 0..9, no done.
REQ-045 SHALL cover: start pulsed while busy, and rst_n low mid-sweep -> start has no effect; on reset all outputs are 0 immediately and the next start runs a clean sweep.
